// File: rtl/fc_in_neuron_loader.sv
// Streams input neurons (two per beat) into the PI dual-port input-neuron banks
// in the FC read controller's layout, then holds fc_enable until fc_done.
module fc_in_neuron_loader #(
  parameter int INNEURON               = 8,
  parameter int PI                     = 2,
  parameter int DATA_WIDTH_FC          = 16,
  parameter int FC_INNEURON_ADDR_WIDTH = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              in_valid,
  input  logic [2*DATA_WIDTH_FC-1:0]        in_data,
  output logic                              in_ready,
  output logic [PI-1:0]                     in_neuron_wren_a_all,
  output logic [PI-1:0]                     in_neuron_wren_b_all,
  output logic [FC_INNEURON_ADDR_WIDTH-1:0] in_neuron_address_a,
  output logic [FC_INNEURON_ADDR_WIDTH-1:0] in_neuron_address_b,
  output logic [DATA_WIDTH_FC-1:0]          in_neuron_data_a,
  output logic [DATA_WIDTH_FC-1:0]          in_neuron_data_b,
  output logic                              fc_enable,
  input  logic                              fc_done,
  output logic                              load_done
);

  localparam int BEATS  = INNEURON / 2;
  localparam int DEPTH  = INNEURON / PI;
  localparam int BPB    = DEPTH / 2;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BANK_W = (PI > 1) ? $clog2(PI) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                            state_r;
  state_t                            next_state_s;
  logic [BEAT_W-1:0]                 beat_r;
  logic                              handshake_s;
  logic                              last_beat_s;
  logic [BANK_W-1:0]                 bank_s;
  logic [PI-1:0]                     bank_onehot_s;
  logic [FC_INNEURON_ADDR_WIDTH-1:0] offset_s;

  assign handshake_s = in_valid & in_ready;
  assign last_beat_s = (beat_r == BEAT_W'(BEATS - 1));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = LOAD;
        else       next_state_s = IDLE;
      end
      LOAD: begin
        if (handshake_s && last_beat_s) next_state_s = RUN;
        else                            next_state_s = LOAD;
      end
      RUN: begin
        if (fc_done) next_state_s = IDLE;
        else         next_state_s = RUN;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      LOAD:    in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Bank and in-bank offset for the current beat; port B takes offset+1
  always_comb begin
    bank_s   = BANK_W'(int'(beat_r) / BPB);
    offset_s = FC_INNEURON_ADDR_WIDTH'(2 * (int'(beat_r) % BPB));
    for (int i = 0; i < PI; i++) begin
      bank_onehot_s[i] = (bank_s == BANK_W'(i));
    end
  end

  // Beat counter, cleared when a load begins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      beat_r <= {BEAT_W{1'b0}};
    end else if (state_r == IDLE && next_state_s == LOAD) begin
      beat_r <= {BEAT_W{1'b0}};
    end else if (handshake_s) begin
      if (last_beat_s) beat_r <= {BEAT_W{1'b0}};
      else             beat_r <= beat_r + BEAT_W'(1);
    end else begin
      beat_r <= beat_r;
    end
  end

  // Registered RAM write port; address and data hold between beats
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_neuron_wren_a_all <= {PI{1'b0}};
      in_neuron_wren_b_all <= {PI{1'b0}};
      in_neuron_address_a  <= {FC_INNEURON_ADDR_WIDTH{1'b0}};
      in_neuron_address_b  <= {FC_INNEURON_ADDR_WIDTH{1'b0}};
      in_neuron_data_a     <= {DATA_WIDTH_FC{1'b0}};
      in_neuron_data_b     <= {DATA_WIDTH_FC{1'b0}};
      load_done            <= 1'b0;
    end else if (handshake_s) begin
      in_neuron_wren_a_all <= bank_onehot_s;
      in_neuron_wren_b_all <= bank_onehot_s;
      in_neuron_address_a  <= offset_s;
      in_neuron_address_b  <= offset_s + FC_INNEURON_ADDR_WIDTH'(1);
      in_neuron_data_a     <= in_data[DATA_WIDTH_FC-1:0];
      in_neuron_data_b     <= in_data[2*DATA_WIDTH_FC-1:DATA_WIDTH_FC];
      load_done            <= last_beat_s;
    end else begin
      in_neuron_wren_a_all <= {PI{1'b0}};
      in_neuron_wren_b_all <= {PI{1'b0}};
      load_done            <= 1'b0;
    end
  end

  // fc_enable tracks RUN one cycle late and drops together with the exit to IDLE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fc_enable <= 1'b0;
    end else begin
      fc_enable <= (state_r == RUN) && (next_state_s == RUN);
    end
  end

endmodule

// File: tb/tb_fc_in_neuron_loader.sv
// Directed bench for fc_in_neuron_loader at default parameters, with a small
// RAM model capturing the write port.
module tb_fc_in_neuron_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [1:0]  wren_a;
  logic [1:0]  wren_b;
  logic [1:0]  addr_a;
  logic [1:0]  addr_b;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic        fc_enable;
  logic        fc_done;
  logic        load_done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] ram_a [0:7];
  logic [15:0] ram_b [0:7];

  fc_in_neuron_loader dut (
    .clock                (clock),
    .reset                (reset),
    .start                (start),
    .in_valid             (in_valid),
    .in_data              (in_data),
    .in_ready             (in_ready),
    .in_neuron_wren_a_all (wren_a),
    .in_neuron_wren_b_all (wren_b),
    .in_neuron_address_a  (addr_a),
    .in_neuron_address_b  (addr_b),
    .in_neuron_data_a     (data_a),
    .in_neuron_data_b     (data_b),
    .fc_enable            (fc_enable),
    .fc_done              (fc_done),
    .load_done            (load_done)
  );

  always #5 clock = ~clock;

  // Model of the two dual-port banks, index = bank*4 + address
  always @(negedge clock) begin
    for (int b = 0; b < 2; b++) begin
      if (wren_a[b]) ram_a[b*4 + int'(addr_a)] = data_a;
      if (wren_b[b]) ram_b[b*4 + int'(addr_b)] = data_b;
    end
  end

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_value(tag, {in_ready, wren_a, wren_b, addr_a, addr_b, data_a, data_b,
                      fc_enable, load_done}, 64'd0);
  endtask

  // Expected write for beat k: bank k/2, port A at 2*(k%2), port B one above
  task automatic expect_write(input int k, input logic [15:0] ev, input logic [15:0] od,
                              input bit last);
    logic [1:0] exp_w;
    exp_w = (k / 2 == 0) ? 2'b01 : 2'b10;
    check_value("wren_a", 64'(wren_a), 64'(exp_w));
    check_value("wren_b", 64'(wren_b), 64'(exp_w));
    check_value("addr_a", 64'(addr_a), 64'(2 * (k % 2)));
    check_value("addr_b", 64'(addr_b), 64'(2 * (k % 2) + 1));
    check_value("data_a", 64'(data_a), 64'(ev));
    check_value("data_b", 64'(data_b), 64'(od));
    check_value("load_done", 64'(load_done), 64'(last));
  endtask

  // Neuron n holds base+n: even neurons on port A, odd on port B
  task automatic check_ram(input logic [15:0] base);
    for (int j = 0; j < 4; j++) begin
      check_value("ram_a", 64'(ram_a[2*j]), 64'(base + 16'(2*j)));
      check_value("ram_b", 64'(ram_b[2*j+1]), 64'(base + 16'(2*j+1)));
    end
  endtask

  // Continuous-valid load of neurons base..base+7, ending one cycle into RUN
  task automatic run_load(input logic [15:0] base);
    logic [15:0] ev;
    logic [15:0] od;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_value("ready_after_start", 64'(in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      ev       = base + 16'(2*k);
      od       = base + 16'(2*k + 1);
      in_valid = 1'b1;
      in_data  = {od, ev};
      cycle();
      expect_write(k, ev, od, k == 3);
      if (k == 3) begin
        check_value("ready_in_run", 64'(in_ready), 64'd0);
        check_value("fc_en_last_write", 64'(fc_enable), 64'd0);
      end
    end
    in_valid = 1'b0;
    cycle();
    check_value("fc_en_rise", 64'(fc_enable), 64'd1);
    check_value("wren_idle", 64'({wren_a, wren_b}), 64'd0);
    check_value("load_done_pulse", 64'(load_done), 64'd0);
    check_ram(base);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic v;
    logic [15:0] ev;
    logic [15:0] od;

    // Reset with random inputs
    reset    = 1'b0;
    start    = 1'(($urandom) & 1);
    in_valid = 1'(($urandom) & 1);
    in_data  = $urandom;
    fc_done  = 1'(($urandom) & 1);
    #1;
    check_all_zero("reset_immediate");
    for (int i = 0; i < 3; i++) begin
      in_data  = $urandom;
      in_valid = ~in_valid;
      cycle();
    end
    check_all_zero("reset_held");
    start = 1'b0; in_valid = 1'b0; fc_done = 1'b0; in_data = 32'd0;
    reset = 1'b1;
    cycle();
    cycle();
    check_value("ready_before_start", 64'(in_ready), 64'd0);

    // Full load of 1..8, then start pulses and fc_done in RUN
    run_load(16'd1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_value("start_in_run_ready", 64'(in_ready), 64'd0);
    check_value("start_in_run_fc_en", 64'(fc_enable), 64'd1);
    cycle();
    cycle();
    fc_done = 1'b1;
    start   = 1'b1;
    cycle();
    fc_done = 1'b0;
    start   = 1'b0;
    check_value("fc_en_fall", 64'(fc_enable), 64'd0);
    check_value("idle_ready", 64'(in_ready), 64'd0);
    cycle();
    check_value("start_with_done_ignored", 64'(in_ready), 64'd0);

    // Bubbly stream 11..18; start and fc_done during LOAD are ignored
    start = 1'b1;
    cycle();
    start = 1'b0;
    nb = 0;
    for (int i = 0; nb < 4 && i < 40; i++) begin
      v        = (i % 3 == 0);
      ev       = 16'd11 + 16'(2*nb);
      od       = 16'd12 + 16'(2*nb);
      in_valid = v;
      in_data  = {od, ev};
      start    = (i == 1);
      fc_done  = (i == 2);
      cycle();
      start   = 1'b0;
      fc_done = 1'b0;
      if (v) begin
        expect_write(nb, ev, od, nb == 3);
        nb++;
      end else begin
        check_value("bubble_wren", 64'({wren_a, wren_b}), 64'd0);
        check_value("bubble_addr_hold", 64'(addr_a), 64'(2 * ((nb - 1) % 2)));
        check_value("bubble_ready", 64'(in_ready), 64'd1);
      end
    end
    check_value("bubble_beats", 64'(nb), 64'd4);
    in_valid = 1'b0;
    cycle();
    check_value("bubble_fc_en", 64'(fc_enable), 64'd1);
    check_ram(16'd11);
    fc_done = 1'b1;
    cycle();
    fc_done = 1'b0;
    check_value("bubble_fc_en_fall", 64'(fc_enable), 64'd0);

    // Reset in the middle of a load, then a complete reload
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = {16'd22 + 16'(2*k), 16'd21 + 16'(2*k)};
      cycle();
    end
    check_value("mid_load_wren", 64'(wren_a), 64'd1);
    reset = 1'b0;
    #1;
    check_all_zero("mid_load_reset");
    in_valid = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    check_value("post_reset_ready", 64'(in_ready), 64'd0);
    run_load(16'd31);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fc_in_neuron_loader.md
# fc_in_neuron_loader

Write-side front end for the fully-connected layer's input-neuron RAM banks. It accepts input neurons from the upstream layer over a valid/ready stream, two neurons per beat, and writes them into the PI dual-port M9K banks. Neurons land in the bank, port and address layout that the FC read controller consumes. Once the whole vector is stored, it raises `fc_enable` to the FC read controller and holds it until that controller reports done.

## Interface

Parameters:
- `INNEURON`, 8: input neurons per vector; must be a multiple of 2*PI.
- `PI`, 2: number of input-neuron RAM banks.
- `DATA_WIDTH_FC`, 16: neuron width in bits.
- `FC_INNEURON_ADDR_WIDTH`, 2: bank address width; must satisfy 2^width ≥ INNEURON/PI.

Ports:
- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  single-cycle request to load one vector.
- `in_valid`  in  1  upstream beat valid.
- `in_data`  in  2*DATA_WIDTH_FC  [DW-1:0] = even neuron, [2DW-1:DW] = odd neuron.
- `in_ready`  out  1  loader accepts a beat.
- `in_neuron_wren_a_all`  out  PI  one-hot port-A write enable per bank.
- `in_neuron_wren_b_all`  out  PI  one-hot port-B write enable per bank.
- `in_neuron_address_a`  out  FC_INNEURON_ADDR_WIDTH  port-A address, shared by all banks.
- `in_neuron_address_b`  out  FC_INNEURON_ADDR_WIDTH  port-B address, shared by all banks.
- `in_neuron_data_a`  out  DATA_WIDTH_FC  port-A write data, shared.
- `in_neuron_data_b`  out  DATA_WIDTH_FC  port-B write data, shared.
- `fc_enable`  out  1  level enable to the FC read controller.
- `fc_done`  in  1  done from the FC read controller.
- `load_done`  out  1  one-cycle pulse when the last beat is written.

## Operation

- Derived constants:
  - BEATS = INNEURON/2.
  - DEPTH = INNEURON/PI neurons per bank.
  - BPB = DEPTH/2 beats per bank.
- FSM states IDLE, LOAD, RUN.
  - IDLE → LOAD on `start`=1.
  - LOAD → RUN on the handshake of beat BEATS-1.
  - RUN → IDLE on `fc_done`=1.
- `start` is ignored outside IDLE.
- Beat counter `beat` runs 0..BEATS-1.
  - Cleared on entry to LOAD.
  - Increments on each handshake (`in_valid` & `in_ready`).
- `in_ready` = (state==LOAD). It is combinational from the registered state and never depends on `in_valid`.
- Layout for beat k: bank = k / BPB, o = 2*(k mod BPB).
  - Even neuron 2k goes to port A at address o.
  - Odd neuron 2k+1 goes to port B at address o+1.
  - Both enables assert only for that bank: bit `bank` of each wren vector.
- Write outputs are registered from the handshake cycle.
  - With no handshake, both wren vectors are 0; address and data hold their last values.
- `load_done` pulses in the cycle the last beat's write is presented.
- `fc_enable` = registered (state==RUN). It deasserts the cycle after `fc_done` is sampled in RUN.
- Address arithmetic is unsigned; the address never exceeds DEPTH-1; no wrap within a vector.
- Reset value of every output is 0: `in_ready`, wren vectors, addresses, data, `fc_enable`, `load_done`. State resets to IDLE and `beat` to 0.
- Reset asserted mid-LOAD or mid-RUN aborts immediately. Partial RAM contents are not cleared; the next `start` rewrites the whole vector.

## Timing

- `start` at edge t puts state in LOAD; `in_ready`=1 from cycle t+1.
- Handshake in cycle c drives wren/address/data in cycle c+1 (one-cycle write latency).
- Back-to-back beats sustain 2 neurons per cycle; bubbles on `in_valid` are allowed.
- Last handshake in cycle c:
  - writes and `load_done` in c+1;
  - state is RUN in c+1, so `in_ready`=0 in c+1;
  - `fc_enable`=1 from c+2, so it rises strictly after the final write.
- `fc_done` sampled in cycle d: `fc_enable`=0 and state IDLE in d+1.
- `start` in the same cycle as `fc_done` is ignored, because state is not yet IDLE.
- `fc_done` outside RUN is ignored.

## Test plan

- Reset: hold `reset`=0 with random inputs -> every output 0; release; `in_ready` stays 0 until `start`.
- Full load, defaults, continuous valid, neurons 1..8 -> writes, then `load_done` in the last write cycle, then `fc_enable`=1 one cycle later:
  - bank0 A0=1, B1=2, A2=3, B3=4;
  - bank1 A0=5, B1=6, A2=7, B3=8.
- Bubbly stream, `in_valid` toggled 1,0,0,1,... -> same 8 writes; no wren in non-handshake cycles; `beat` advances only on handshakes.
- `start` pulsed during LOAD and during RUN -> no restart; counter and writes unaffected.
- `fc_done` pulse 5 cycles into RUN -> `fc_enable` falls next cycle; a following `start` reloads from beat 0 into bank0 addresses 0/1.
- `reset` asserted after beat 2 -> outputs 0 immediately; after release and `start`, the full 4-beat load completes correctly.
